// File: rtl/mem_sched_ctrl.sv
// mem_sched_ctrl: shares one memory port between I-cache fill and data side.
// Data-first priority, instruction anti-starvation, one-cycle release gap.
//
// Ports:
//   clk, reset (async active-low)
//   petitionInstr/addressInstr          instruction fill request
//   petitionDat/addressDat/weDat        data fill or write-back request
//   serviceReady                        memory completion strobe
//   petitionMem/addressMem/weMem        latched request to memory
//   serviceReadyInstr/serviceReadyDat   completion to each requester
//   busy, grantOwner (0 = instr, 1 = data)
//   perfInstrGrants/perfDatGrants/perfStallCycles  saturating counters
//
// Optional feature: define MEM_SCHED_PERF_EN to build the perf counters;
// otherwise the perf outputs are tied to 0.
module mem_sched_ctrl #(
    parameter int addr_width   = 16,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  petitionInstr,
    input  logic [addr_width-1:0] addressInstr,
    input  logic                  petitionDat,
    input  logic [addr_width-1:0] addressDat,
    input  logic                  weDat,
    input  logic                  serviceReady,
    output logic                  petitionMem,
    output logic [addr_width-1:0] addressMem,
    output logic                  weMem,
    output logic                  serviceReadyInstr,
    output logic                  serviceReadyDat,
    output logic                  busy,
    output logic                  grantOwner,
    output logic [CNT_WIDTH-1:0]  perfInstrGrants,
    output logic [CNT_WIDTH-1:0]  perfDatGrants,
    output logic [CNT_WIDTH-1:0]  perfStallCycles
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  own_q, own_d;
    logic [3:0]            starve_q, starve_d;
    logic                  grant_i, grant_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            own_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            own_q    <= own_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        own_d    = own_q;
        starve_d = starve_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Data wins unless instruction has waited out its budget.
                if (petitionDat &&
                    !(petitionInstr && starve_q == STARVE_MAX)) begin
                    grant_d = 1'b1;
                end else if (petitionInstr) begin
                    grant_i = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (serviceReady) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_d) begin
            state_d = SERVE_D;
            addr_d  = addressDat;
            we_d    = weDat;
            own_d   = 1'b1;
            if (petitionInstr && starve_q != STARVE_MAX) begin
                starve_d = starve_q + 4'd1;
            end
        end
        if (grant_i) begin
            state_d  = SERVE_I;
            addr_d   = addressInstr;
            we_d     = 1'b0;
            own_d    = 1'b0;
            starve_d = '0;
        end
    end

    assign petitionMem       = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign addressMem        = addr_q;
    assign weMem             = we_q;
    assign grantOwner        = own_q;
    assign busy              = (state_q != IDLE);
    assign serviceReadyInstr = serviceReady && (state_q == SERVE_I);
    assign serviceReadyDat   = serviceReady && (state_q == SERVE_D);

`ifdef MEM_SCHED_PERF_EN
    logic [CNT_WIDTH-1:0] pinstr_q, pdat_q, pstall_q;
    logic                 stall;

    // A cycle stalls when any raised petition is not the one being served.
    assign stall = (petitionInstr && state_q != SERVE_I) ||
                   (petitionDat   && state_q != SERVE_D);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pinstr_q <= '0;
            pdat_q   <= '0;
            pstall_q <= '0;
        end else begin
            if (grant_i && !(&pinstr_q)) begin
                pinstr_q <= pinstr_q + 1'b1;
            end
            if (grant_d && !(&pdat_q)) begin
                pdat_q <= pdat_q + 1'b1;
            end
            if (stall && !(&pstall_q)) begin
                pstall_q <= pstall_q + 1'b1;
            end
        end
    end

    assign perfInstrGrants = pinstr_q;
    assign perfDatGrants   = pdat_q;
    assign perfStallCycles = pstall_q;
`else
    assign perfInstrGrants = '0;
    assign perfDatGrants   = '0;
    assign perfStallCycles = '0;
`endif

endmodule

// File: tb/tb_mem_sched_ctrl.sv
// tb_mem_sched_ctrl: directed vector table plus hand-written sequences
// for rotation, starvation, perf counters and mid-transaction reset.
module tb_mem_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        petitionInstr, petitionDat, weDat, serviceReady;
    logic [15:0] addressInstr, addressDat;
    logic        petitionMem, weMem, serviceReadyInstr, serviceReadyDat;
    logic        busy, grantOwner;
    logic [15:0] addressMem;
    logic [15:0] perfInstrGrants, perfDatGrants, perfStallCycles;

    int checks = 0;
    int errors = 0;

    mem_sched_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .petitionInstr     (petitionInstr),
        .addressInstr      (addressInstr),
        .petitionDat       (petitionDat),
        .addressDat        (addressDat),
        .weDat             (weDat),
        .serviceReady      (serviceReady),
        .petitionMem       (petitionMem),
        .addressMem        (addressMem),
        .weMem             (weMem),
        .serviceReadyInstr (serviceReadyInstr),
        .serviceReadyDat   (serviceReadyDat),
        .busy              (busy),
        .grantOwner        (grantOwner),
        .perfInstrGrants   (perfInstrGrants),
        .perfDatGrants     (perfDatGrants),
        .perfStallCycles   (perfStallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pi;
        logic [15:0] ai;
        logic        pd;
        logic [15:0] ad;
        logic        wd;
        logic        sr;
        logic        pm;
        logic [15:0] am;
        logic        wm;
        logic        si;
        logic        sd;
        logic        bz;
        logic        ow;
    } vec_t;

    vec_t vec[14];

    function automatic vec_t mk(
        input logic pi, input logic [15:0] ai,
        input logic pd, input logic [15:0] ad,
        input logic wd, input logic sr,
        input logic pm, input logic [15:0] am, input logic wm,
        input logic si, input logic sd, input logic bz, input logic ow);
        vec_t v;
        v.pi = pi; v.ai = ai; v.pd = pd; v.ad = ad; v.wd = wd; v.sr = sr;
        v.pm = pm; v.am = am; v.wm = wm; v.si = si; v.sd = sd;
        v.bz = bz; v.ow = ow;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        petitionInstr = 1'b0;
        petitionDat   = 1'b0;
        addressInstr  = '0;
        addressDat    = '0;
        weDat         = 1'b0;
        serviceReady  = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] got_o, exp_o;
        logic       exp_own[8];
        logic       dropI, dropD;
        int         lat, g;

        //       pi  ai        pd  ad        wd sr | pm am        wm si sd bz ow
        vec[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        vec[1]  = mk(0, 16'h0000, 1, 16'h0400, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        vec[2]  = mk(0, 16'h0000, 1, 16'h0400, 1, 0, 1, 16'h0400, 1, 0, 0, 1, 1);
        vec[3]  = mk(0, 16'h0000, 1, 16'h1234, 0, 0, 1, 16'h0400, 1, 0, 0, 1, 1);
        vec[4]  = mk(0, 16'h0000, 1, 16'h1234, 0, 0, 1, 16'h0400, 1, 0, 0, 1, 1);
        vec[5]  = mk(0, 16'h0000, 1, 16'h1234, 0, 1, 1, 16'h0400, 1, 0, 1, 1, 1);
        vec[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0400, 1, 0, 0, 1, 1);
        vec[7]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0400, 1, 0, 0, 0, 0);
        vec[8]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0400, 1, 0, 0, 0, 0);
        vec[9]  = mk(1, 16'h020c, 0, 16'h0000, 0, 0, 0, 16'h0400, 1, 0, 0, 0, 0);
        vec[10] = mk(1, 16'hffff, 0, 16'h0000, 1, 0, 1, 16'h020c, 0, 0, 0, 1, 0);
        vec[11] = mk(1, 16'hffff, 0, 16'h0000, 1, 1, 1, 16'h020c, 0, 1, 0, 1, 0);
        vec[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h020c, 0, 0, 0, 1, 0);
        vec[13] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h020c, 0, 0, 0, 0, 0);

        exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        do_reset();
        #1;
        chk("reset_pm_bz", {30'd0, petitionMem, busy}, 32'd0);

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            petitionInstr = vec[i].pi;
            addressInstr  = vec[i].ai;
            petitionDat   = vec[i].pd;
            addressDat    = vec[i].ad;
            weDat         = vec[i].wd;
            serviceReady  = vec[i].sr;
            #1;
            got_o = {petitionMem, weMem, serviceReadyInstr,
                     serviceReadyDat, busy, vec[i].bz ? grantOwner : 1'b0};
            exp_o = {vec[i].pm, vec[i].wm, vec[i].si,
                     vec[i].sd, vec[i].bz, vec[i].bz ? vec[i].ow : 1'b0};
            chk($sformatf("vec%0d_ctl", i), {26'd0, got_o}, {26'd0, exp_o});
            chk($sformatf("vec%0d_addr", i), {16'd0, addressMem},
                {16'd0, vec[i].am});
        end

        // Rotation: both petitions always pending, memory latency 2.
        do_reset();
        dropI = 1'b0;
        dropD = 1'b0;
        lat   = 0;
        g     = 0;
        for (int cyc = 0; cyc < 200 && g < 8; cyc++) begin
            @(negedge clk);
            petitionInstr = !dropI;
            petitionDat   = !dropD;
            addressInstr  = 16'h0100;
            addressDat    = 16'h0200;
            weDat         = 1'b0;
            lat           = petitionMem ? lat + 1 : 0;
            serviceReady  = (lat == 2);
            #1;
            if (busy && grantOwner) begin
                chk("srI_in_serveD", {31'd0, serviceReadyInstr}, 32'd0);
            end
            if (petitionMem && lat == 1) begin
                chk($sformatf("grant%0d_owner", g), {31'd0, grantOwner},
                    {31'd0, exp_own[g]});
                if (g == 3) begin
`ifdef MEM_SCHED_PERF_EN
                    chk("perf_dat", {16'd0, perfDatGrants}, 32'd3);
                    chk("perf_instr", {16'd0, perfInstrGrants}, 32'd1);
                    chk("perf_stall", {16'd0, perfStallCycles}, 32'd13);
`else
                    chk("perf_zero", {perfDatGrants, perfInstrGrants}
                        | {16'd0, perfStallCycles}, 32'd0);
`endif
                end
                g++;
            end
            dropI = serviceReadyInstr;
            dropD = serviceReadyDat;
        end
        chk("rotation_done", g, 8);

        // Reset asserted two cycles into SERVE_D.
        do_reset();
        @(negedge clk);
        petitionDat   = 1'b1;
        addressDat    = 16'h0800;
        weDat         = 1'b1;
        petitionInstr = 1'b1;
        addressInstr  = 16'h0300;
        @(negedge clk);
        #1;
        chk("rst_pre_owner", {30'd0, petitionMem, grantOwner}, 32'd3);
        @(negedge clk);
        #2;
        serviceReady = 1'b1;
        reset        = 1'b0;
        #1;
        chk("rst_async_ctl", {27'd0, petitionMem, weMem, busy, grantOwner,
            serviceReadyDat}, 32'd0);
        chk("rst_async_addr", {16'd0, addressMem}, 32'd0);
        @(negedge clk);
        reset        = 1'b1;
        serviceReady = 1'b0;
        petitionDat  = 1'b0;
        #1;
        chk("rst_idle", {30'd0, busy, petitionMem}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_instr_ctl", {29'd0, petitionMem, grantOwner, weMem},
            32'd4);
        chk("rst_instr_addr", {16'd0, addressMem}, 32'h0300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
